// File: rtl/legv8_multicycle_sequencer.sv
// rtl/legv8_multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 core
//
// Purpose: steps each instruction through fetch, decode, execute, memory and
// writeback. Each step is paced on the instruction and data memory ready
// handshakes. Drives the per-cycle PC/IR/register-file/data-memory strobes.
// Outputs are decoded combinationally from the registered state and the
// opcode class latched in DECODE (Moore style). The one exception is pc_src
// for conditional branches, which follows cond_true in EXEC.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 permits fetching new instructions (sampled in IDLE and at retirement)
//   opcode[10:0]        IR[31:21], valid from DECODE onward
//   cond_true           branch condition from the datapath, used in EXEC
//   imem_ready          instruction word valid this cycle
//   dmem_ready          data access completes this cycle
//   imem_req, ir_write  fetch request / IR load
//   pc_write, pc_src    PC update / select (00 PC+4, 01 branch target)
//   reg_write, wb_src   register write / writeback select (00 ALU, 01 mem, 10 PC+4)
//   wb_reg_sel[4:0]     RETURN_REG for link writes, else 0 (use Rd)
//   dmem_read/write     data memory strobes
//   state[2:0]          current state encoding
//   instr_done          one-cycle retire pulse
//   illegal             sticky unrecognised-opcode flag
//
// Optional feature: define SEQ_PERF_CNT_EN to add cycle_count[31:0] and
// instr_count[31:0] performance counters.
module legv8_multicycle_sequencer #(
  parameter int unsigned RETURN_REG = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [10:0] opcode,
  input  logic        cond_true,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_src,
  output logic [4:0]  wb_reg_sel,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_B, C_BL, C_CB, C_ILL
  } class_t;

  localparam logic [4:0] RET_SEL = 5'(RETURN_REG);

  state_t state_q, state_d;
  class_t class_q, class_d;
  logic   illegal_q, illegal_d;
  class_t dec_class;

  // Opcode classification; only consumed in DECODE, so opcode activity in
  // other states never reaches the class register.
  always_comb begin
    casez (opcode)
      11'b10001011000, 11'b11001011000, 11'b11101011000,
      11'b10001010000, 11'b10101010000,
      11'b11010011011, 11'b11010011010:                   dec_class = C_R;
      11'b1001000100?, 11'b1101000100?:                   dec_class = C_I;
      11'b11111000010:                                    dec_class = C_LD;
      11'b11111000000:                                    dec_class = C_ST;
      11'b000101?????:                                    dec_class = C_B;
      11'b100101?????:                                    dec_class = C_BL;
      11'b10110100???, 11'b10110101???, 11'b01010100???:  dec_class = C_CB;
      default:                                            dec_class = C_ILL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    illegal_d  = illegal_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    wb_src     = 2'b00;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_I:   state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          C_B: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
          end
          C_BL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            reg_write  = 1'b1;
            wb_src     = 2'b10;
            instr_done = 1'b1;
          end
          C_CB: begin
            pc_write   = 1'b1;
            pc_src     = cond_true ? 2'b01 : 2'b00;
            instr_done = 1'b1;
          end
          default: state_d = S_TRAP;  // illegal class never reaches EXEC
        endcase
      end
      S_MEM: begin
        if (class_q == C_LD) begin
          dmem_read = 1'b1;
          if (dmem_ready) state_d = S_WB;
        end else begin
          dmem_write = 1'b1;
          if (dmem_ready) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_src     = (class_q == C_LD) ? 2'b01 : 2'b00;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    // run is only consulted at retirement, so an in-flight instruction always completes
    if (instr_done) state_d = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= C_R;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
    end
  end

  assign state      = state_q;
  assign illegal    = illegal_q;
  assign wb_reg_sel = (wb_src == 2'b10) ? RET_SEL : 5'd0;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_count <= cycle_count + 32'd1;
      if (instr_done) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// tb/tb_legv8_multicycle_sequencer.sv - self-checking bench for legv8_multicycle_sequencer
module tb_legv8_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [10:0] opcode;
  logic        cond_true;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, ir_write, pc_write, reg_write;
  logic        dmem_read, dmem_write, instr_done, illegal;
  logic [1:0]  pc_src, wb_src;
  logic [4:0]  wb_reg_sel;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  legv8_multicycle_sequencer #(.RETURN_REG(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .cond_true  (cond_true),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_src     (wb_src),
    .wb_reg_sel (wb_reg_sel),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_word();
    return int'({imem_req, ir_write, pc_write, pc_src, reg_write, wb_src, wb_reg_sel,
                 dmem_read, dmem_write, instr_done, illegal});
  endfunction

  typedef struct {
    logic [10:0] op;
    logic        cond;
    int          iw;       // imem wait cycles
    int          dw;       // dmem wait cycles
    bit          scramble; // drive garbage opcode outside DECODE
    bit          trap;
    int          lat;      // retire cycle, or TRAP-entry cycle for trap vectors
    int          pcs;
    int          wbs;
    int          regw;     // reg_write cycles over the instruction
    int          rsel;
    int          rd;       // dmem_read cycles
    int          wr;       // dmem_write cycles
  } vec_t;

  typedef struct {
    int idx, lat, pcs, wbs, regw, rsel, rd, wr;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [2:0] trace[0:63];

  function automatic vec_t mk(input logic [10:0] op, input logic c, input int iw, input int dw,
                              input bit scr, input bit trap, input int lat, input int pcs,
                              input int wbs, input int regw, input int rsel, input int rd,
                              input int wr);
    vec_t v;
    v.op = op; v.cond = c; v.iw = iw; v.dw = dw; v.scramble = scr; v.trap = trap;
    v.lat = lat; v.pcs = pcs; v.wbs = wbs; v.regw = regw; v.rsel = rsel; v.rd = rd; v.wr = wr;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; cond_true = 1'b0; opcode = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic retire(input int c, input int rdc, input int wrc, input int rwc, input int pwc);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_retire", 1, 0);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d latency", e.idx), c, e.lat);
      check($sformatf("v%0d pc_src", e.idx), int'(pc_src), e.pcs);
      check($sformatf("v%0d wb_src", e.idx), int'(wb_src), e.wbs);
      check($sformatf("v%0d wb_reg_sel", e.idx), int'(wb_reg_sel), e.rsel);
      check($sformatf("v%0d reg_write_cycles", e.idx), rwc, e.regw);
      check($sformatf("v%0d pc_write_cycles", e.idx), pwc, 1);
      check($sformatf("v%0d dmem_read_cycles", e.idx), rdc, e.rd);
      check($sformatf("v%0d dmem_write_cycles", e.idx), wrc, e.wr);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   fw = 0, dwc = 0, rdc = 0, wrc = 0, rwc = 0, pwc = 0, hold_bad = 0;
    bit   done = 1'b0;
    exp_t e;
    do_reset();
    run = 1'b1; opcode = v.op; cond_true = v.cond;
    if (!v.trap) begin
      e.idx = idx; e.lat = v.lat; e.pcs = v.pcs; e.wbs = v.wbs; e.regw = v.regw;
      e.rsel = v.rsel; e.rd = v.rd; e.wr = v.wr;
      sb.push_back(e);
    end
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      imem_ready = (state == 3'd1) && (fw >= v.iw);
      if (state == 3'd1) fw++;
      dmem_ready = (state == 3'd4) && (dwc >= v.dw);
      if (state == 3'd4) dwc++;
      opcode = (v.scramble && state != 3'd2) ? 11'h7FF : v.op;
      #1;
      trace[c] = state;
      if (dmem_read)  rdc++;
      if (dmem_write) wrc++;
      if (reg_write)  rwc++;
      if (pc_write)   pwc++;
      if ((dmem_read && dmem_write) || (pc_write && ir_write) || pc_src[1]) hold_bad++;
      if (v.trap && state == 3'd6) begin
        done = 1'b1;
        check($sformatf("v%0d trap_entry_cycle", idx), c, v.lat);
        for (int k = 0; k < 12; k++) begin
          @(negedge clk); #1;
          if (state != 3'd6 || !illegal || outs_word() != 1) hold_bad++;
        end
        check($sformatf("v%0d trap_hold_errors", idx), hold_bad, 0);
        rst = 1'b1;
        #1;
        check($sformatf("v%0d trap_rst_state", idx), int'(state), 0);
        check($sformatf("v%0d trap_rst_illegal", idx), int'(illegal), 0);
      end else if (instr_done) begin
        done = 1'b1;
        check($sformatf("v%0d strobe_exclusion", idx), hold_bad, 0);
        retire(c, rdc, wrc, rwc, pwc);
      end
    end
    if (!done) begin
      check($sformatf("v%0d timeout", idx), 1, 0);
      sb.delete();
    end
`ifdef SEQ_PERF_CNT_EN
    if (done && !v.trap) begin
      @(negedge clk); #1;
      check($sformatf("v%0d cycle_count", idx), int'(cycle_count), v.lat);
      check($sformatf("v%0d instr_count", idx), int'(instr_count), 1);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  c;
    bit  seen;
    rst = 1'b1; run = 1'b0; opcode = '0; cond_true = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    //           op              c     iw dw scr trap lat pcs wbs rw rsel rd wr
    vecs.push_back(mk(11'b10001011000, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // ADD
    vecs.push_back(mk(11'b11001011000, 1'b0, 1, 0, 0, 0, 5, 0, 0, 1, 0,  0, 0)); // SUB, 1 fetch wait
    vecs.push_back(mk(11'b11101011000, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // SUBS
    vecs.push_back(mk(11'b10001010000, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // AND
    vecs.push_back(mk(11'b10101010000, 1'b0, 2, 0, 0, 0, 6, 0, 0, 1, 0,  0, 0)); // ORR, 2 fetch waits
    vecs.push_back(mk(11'b11010011011, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // LSL
    vecs.push_back(mk(11'b11010011010, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // LSR
    vecs.push_back(mk(11'b10010001001, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // ADDI
    vecs.push_back(mk(11'b11010001000, 1'b0, 0, 0, 0, 0, 4, 0, 0, 1, 0,  0, 0)); // SUBI
    vecs.push_back(mk(11'b11111000010, 1'b0, 0, 0, 0, 0, 5, 0, 1, 1, 0,  1, 0)); // LDUR
    vecs.push_back(mk(11'b11111000010, 1'b0, 0, 3, 0, 0, 8, 0, 1, 1, 0,  4, 0)); // LDUR, 3 dmem waits
    vecs.push_back(mk(11'b11111000000, 1'b0, 0, 0, 0, 0, 4, 0, 0, 0, 0,  0, 1)); // STUR
    vecs.push_back(mk(11'b11111000000, 1'b0, 2, 2, 0, 0, 8, 0, 0, 0, 0,  0, 3)); // STUR, waits both
    vecs.push_back(mk(11'b00010100101, 1'b0, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0)); // B
    vecs.push_back(mk(11'b10010100000, 1'b0, 0, 0, 0, 0, 3, 1, 2, 1, 30, 0, 0)); // BL
    vecs.push_back(mk(11'b10110100000, 1'b1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0)); // CBZ taken
    vecs.push_back(mk(11'b10110100000, 1'b0, 0, 0, 0, 0, 3, 0, 0, 0, 0,  0, 0)); // CBZ not taken
    vecs.push_back(mk(11'b10110101010, 1'b1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0)); // CBNZ taken
    vecs.push_back(mk(11'b01010100011, 1'b0, 0, 0, 0, 0, 3, 0, 0, 0, 0,  0, 0)); // B.cond not taken
    vecs.push_back(mk(11'b01010100111, 1'b1, 1, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0)); // B.cond taken, fetch wait
    vecs.push_back(mk(11'b10001011000, 1'b0, 0, 0, 1, 0, 4, 0, 0, 1, 0,  0, 0)); // ADD, opcode garbage outside DECODE
    vecs.push_back(mk(11'b11111000010, 1'b0, 0, 1, 1, 0, 6, 0, 1, 1, 0,  2, 0)); // LDUR, opcode garbage outside DECODE
    vecs.push_back(mk(11'b00000000000, 1'b0, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0)); // illegal
    vecs.push_back(mk(11'b11111111111, 1'b0, 1, 0, 0, 1, 4, 0, 0, 0, 0,  0, 0)); // illegal, fetch wait
    vecs.push_back(mk(11'b10001011001, 1'b0, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0)); // near-ADD illegal

    // reset state
    @(negedge clk); #1;
    check("reset_state", int'(state), 0);
    check("reset_outputs", outs_word(), 0);

    // IDLE holds without run; first FETCH on the first edge with run=1
    do_reset();
    @(negedge clk); @(negedge clk); #1;
    check("idle_no_run_state", int'(state), 0);
    check("idle_no_run_imem_req", int'(imem_req), 0);
    run = 1'b1;
    @(negedge clk); #1;
    check("first_fetch_state", int'(state), 1);
    check("first_fetch_imem_req", int'(imem_req), 1);

    // table vectors
    foreach (vecs[i]) begin
      run_vec(i, vecs[i]);
      if (i == 0) begin
        check("add_trace_c1", int'(trace[1]), 1);
        check("add_trace_c2", int'(trace[2]), 2);
        check("add_trace_c3", int'(trace[3]), 3);
        check("add_trace_c4", int'(trace[4]), 5);
      end
    end
    check("scoreboard_drained", sb.size(), 0);

    // run dropped mid-instruction: instruction completes, then IDLE
    do_reset();
    run = 1'b1; opcode = 11'b10001011000; imem_ready = 1'b1; dmem_ready = 1'b1;
    seen = 1'b0;
    c = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (state == 3'd2) run = 1'b0;
      #1;
      if (instr_done) begin seen = 1'b1; c = k; end
    end
    check("run_drop_retire_cycle", c, 4);
    @(negedge clk); #1;
    check("run_drop_idle_state", int'(state), 0);
    @(negedge clk); @(negedge clk); #1;
    check("run_drop_idle_hold", int'(state), 0);
    check("run_drop_no_fetch", int'(imem_req), 0);

    // asynchronous reset mid-FETCH
    do_reset();
    run = 1'b1; imem_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("fetch_wait_imem_req", int'(imem_req), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_fetch_imem_req", int'(imem_req), 0);
    check("rst_mid_fetch_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_first_fetch", int'(state), 1);

    // asynchronous reset mid-MEM of STUR; write is dropped, not retried
    do_reset();
    run = 1'b1; opcode = 11'b11111000000; imem_ready = 1'b1; dmem_ready = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk); #1;
      if (state == 3'd4) seen = 1'b1;
    end
    check("stur_reaches_mem", int'(seen), 1);
    check("stur_mem_dmem_write", int'(dmem_write), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mem_dmem_write", int'(dmem_write), 0);
    check("rst_mid_mem_state", int'(state), 0);
    check("rst_mid_mem_outputs", outs_word(), 0);
`ifdef SEQ_PERF_CNT_EN
    check("rst_mid_mem_cycle_count", int'(cycle_count), 0);
    check("rst_mid_mem_instr_count", int'(instr_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("no_write_retry", int'(dmem_write), 0);
    check("no_write_retry_state", int'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_sequencer.md
# legv8_multicycle_sequencer

Multi-cycle instruction sequencer for the LEGv8 core. It steps each instruction through fetch, decode, execute, memory and writeback, and paces each step on instruction and data memory ready handshakes. It drives the per-cycle enables and selects for the PC, IR, register file and data memory. The combinational ControlUnit keeps supplying the static ALU and immediate decode alongside it.

## Interface
Parameters:
- `RETURN_REG`, default 30: register index written by BL; forwarded unchanged on `wb_reg_sel`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level input; 1 permits fetching new instructions.
- `opcode`  in  11  IR[31:21]; valid from the DECODE state onward.
- `cond_true`  in  1  branch condition from the datapath (CBZ zero test / B.cond flags); sampled in EXEC.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access completes this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  PC select: 00 = PC+4, 01 = branch target, 1x = reserved (never driven).
- `reg_write`  out  1  register file write enable.
- `wb_src`  out  2  writeback select: 00 = ALU, 01 = data memory, 10 = PC+4.
- `wb_reg_sel`  out  5  equals `RETURN_REG` when wb_src = 10, otherwise 0 (use Rd).
- `dmem_read`, `dmem_write`  out  1 each  data memory strobes.
- `state`  out  3  current state encoding.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  sticky; set when an unrecognised opcode is decoded.

## Operation
States: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.

Opcode classes are latched into a class register in DECODE:
- R: ADD 10001011000, SUB 11001011000, SUBS 11101011000, AND 10001010000, ORR 10101010000, LSL 11010011011, LSR 11010011010.
- I: ADDI 1001000100x, SUBI 1101000100x.
- LD: LDUR 11111000010.
- ST: STUR 11111000000.
- B: 000101xxxxx.
- BL: 100101xxxxx.
- CB: CBZ 10110100xxx, CBNZ 10110101xxx, B.cond 01010100xxx.
- Anything else is illegal.

Transitions:
- IDLE: `run`=1 → FETCH.
- FETCH: `imem_req`=1. Waits indefinitely for `imem_ready`. On `imem_ready`: `ir_write`=1, → DECODE.
- DECODE: illegal → TRAP; otherwise → EXEC.
- EXEC, class R/I: → WB.
- EXEC, class LD/ST: → MEM.
- EXEC, class B: `pc_write`=1, `pc_src`=01, `instr_done`=1, → next.
- EXEC, class BL: as B, plus `reg_write`=1, `wb_src`=10.
- EXEC, class CB: `pc_write`=1, `pc_src` = `cond_true` ? 01 : 00, `instr_done`=1, → next.
- MEM: `dmem_read` (LD) or `dmem_write` (ST) is held until `dmem_ready`.
  - LD with ready: → WB.
  - ST with ready: `pc_write`=1, `pc_src`=00, `instr_done`=1, → next.
- WB: `reg_write`=1, `wb_src` = 00 (R/I) or 01 (LD), `pc_write`=1, `pc_src`=00, `instr_done`=1, → next.
- "next" means FETCH if `run`=1, else IDLE. `run` is only sampled in IDLE and at retirement; an instruction in flight always completes.
- TRAP: all strobes 0, `illegal`=1. Only `rst` exits TRAP.
- All outputs not listed for a state are 0.
- `dmem_read` and `dmem_write` are never both 1. `pc_write` and `ir_write` are never both 1.

## Timing
- Outputs are combinational from `state` and the latched class (Moore style), except `pc_src` in CB/EXEC, which follows `cond_true` in the same cycle.
- Retire latency with zero-wait memories, counted from the first FETCH cycle:
  - R/I: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - B/BL/CB: 3 cycles.
- Each wait cycle on `imem_ready` or `dmem_ready` adds exactly one cycle.
- `rst` asserted at any time, including mid-FETCH or mid-MEM:
  - `state` = IDLE and every output = 0 immediately (asynchronously), including `illegal`.
  - Any outstanding memory request is dropped and never retried.
- First FETCH occurs on the first rising edge after `rst` deasserts with `run`=1.
- `opcode` changes outside DECODE have no effect on the latched class.

## Configuration
- `SEQ_PERF_CNT_EN` defined:
  - Adds outputs `cycle_count` [31:0] and `instr_count` [31:0], both reset to 0.
  - `cycle_count` increments on every clock in which state ≠ IDLE and ≠ TRAP.
  - `instr_count` increments on each `instr_done` pulse.
  - Both counters wrap modulo 2^32.
- Undefined: the counter ports and logic do not exist. All other behaviour is identical.

## Test plan
- ADD 10001011000, zero-wait memory, `run`=1 → states 1,2,3,5; `instr_done` on cycle 4; `reg_write`=1 with `wb_src`=00 in WB only.
- LDUR 11111000010 with `dmem_ready` held low for 3 cycles → `dmem_read` high for 4 cycles; then WB with `wb_src`=01; total retire latency 8 cycles.
- CBZ 10110100000: `cond_true`=1 → `pc_src`=01 in EXEC; repeat with `cond_true`=0 → `pc_src`=00; both retire in 3 cycles.
- BL 10010100000 → in EXEC, `reg_write`=1, `wb_src`=10, `wb_reg_sel`=30, `pc_src`=01.
- Opcode 00000000000 → TRAP, `illegal`=1 held for 10+ cycles; `rst` pulse → IDLE, `illegal`=0.
- `rst` asserted mid-MEM of STUR with `dmem_write`=1 → `dmem_write` drops in the same cycle; with the counter macro defined, both counters read 0 afterwards.
